// File: rtl/keypad_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the keypad debouncer.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam int DEF_CODE_W          = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY    = 24000000;
    localparam int DEF_REPEAT_PERIOD   = 6000000;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/keypad_debounce_stable_timer.sv
// Saturating up-counter; o_done flags the enabled edge on which the count reaches i_target.
module stable_timer
    import keypad_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_target,
    output logic         o_done
);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_next;

    assign w_next = {1'b0, r_cnt} + {{W{1'b0}}, 1'b1};
    assign o_done = i_en && (w_next == {1'b0, i_target});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(MAX))) begin
            r_cnt <= w_next[W-1:0];
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad debouncer with press/release event FSM.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CODE_W          = DEF_CODE_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] keypad_val,
    input  logic              button_on,
    output logic [CODE_W-1:0] no_bounce_keypad,
    output logic              key_valid,
    output logic              key_press,
    output logic              key_release
);

    localparam int W_DB = cnt_width(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("keypad_debounce: cycle parameters must be >= 1");
    end

    state_t            r_state;
    logic [CODE_W-1:0] r_cand;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_press;
    logic              r_release;

    logic w_same_cand;
    logic w_same_code;
    logic w_db_clr;
    logic w_db_en;
    logic w_db_done;
    logic w_rpt_done;

    assign w_same_cand = button_on && (keypad_val == r_cand);
    assign w_same_code = button_on && (keypad_val == r_code);

    // The debounce count only advances on stable samples; any other edge restarts it.
    always_comb begin
        w_db_clr = 1'b1;
        w_db_en  = 1'b0;
        case (r_state)
            PRESS_WAIT: begin
                if (w_same_cand) begin
                    w_db_clr = 1'b0;
                    w_db_en  = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (!w_same_code) begin
                    w_db_clr = 1'b0;
                    w_db_en  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    stable_timer #(.MAX(DEBOUNCE_CYCLES)) u_db_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_db_clr),
        .i_en     (w_db_en),
        .i_target (W_DB'(DEBOUNCE_CYCLES)),
        .o_done   (w_db_done)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int W_RPT   = cnt_width(RPT_MAX);

    logic             r_rpt_first;
    logic             w_rpt_en;
    logic [W_RPT-1:0] w_rpt_target;

    // Restarts on every entry to HELD and after each repeat strobe.
    assign w_rpt_en     = (r_state == HELD) && w_same_code;
    assign w_rpt_target = r_rpt_first ? W_RPT'(REPEAT_DELAY) : W_RPT'(REPEAT_PERIOD);

    stable_timer #(.MAX(RPT_MAX)) u_rpt_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (!w_rpt_en || w_rpt_done),
        .i_en     (w_rpt_en),
        .i_target (w_rpt_target),
        .o_done   (w_rpt_done)
    );
`else
    assign w_rpt_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cand    <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rpt_first <= 1'b1;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (r_state != HELD) r_rpt_first <= 1'b1;
            else if (w_rpt_done) r_rpt_first <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (button_on) begin
                        r_cand  <= keypad_val;
                        r_state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!button_on) begin
                        r_state <= IDLE;
                    end else if (keypad_val != r_cand) begin
                        r_cand <= keypad_val;
                    end else if (w_db_done) begin
                        r_state <= HELD;
                        r_code  <= r_cand;
                        r_valid <= 1'b1;
                        r_press <= 1'b1;
                    end
                end
                HELD: begin
                    // A different code while held counts as a release (rollover).
                    if (!w_same_code) r_state <= RELEASE_WAIT;
                    else if (w_rpt_done) r_press <= 1'b1;
                end
                RELEASE_WAIT: begin
                    if (w_same_code) begin
                        r_state <= HELD;
                    end else if (w_db_done) begin
                        r_state   <= IDLE;
                        r_valid   <= 1'b0;
                        r_release <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign no_bounce_keypad = r_code;
    assign key_valid        = r_valid;
    assign key_press        = r_press;
    assign key_release      = r_release;

endmodule

// File: tb/tb_keypad_debounce.sv
// Directed bench for keypad_debounce (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
module tb_keypad_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keypad_val;
    logic       button_on;
    logic [7:0] code;
    logic       valid, press, release_s;
    logic [7:0] code1;
    logic       valid1, press1, release1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    keypad_debounce #(
        .CODE_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) u_dut (
        .clk(clk), .reset(reset), .keypad_val(keypad_val), .button_on(button_on),
        .no_bounce_keypad(code), .key_valid(valid), .key_press(press), .key_release(release_s)
    );

    // Minimum debounce length, exercised alongside the main instance.
    keypad_debounce #(
        .CODE_W(8), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) u_dut1 (
        .clk(clk), .reset(reset), .keypad_val(keypad_val), .button_on(button_on),
        .no_bounce_keypad(code1), .key_valid(valid1), .key_press(press1), .key_release(release1)
    );

    task automatic do_reset();
        reset = 1'b0; button_on = 1'b0; keypad_val = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; button_on = 1'b0; keypad_val = 8'h00;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({code, valid, press, release_s} !== 11'd0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=0", {code, valid, press, release_s});
        end
        reset = 1'b1; button_on = 1'b1; keypad_val = 8'h82;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({code, valid, press, release_s} !== 11'd0) begin
            n_fail++; $display("FAIL reset_midpress got=%h exp=0", {code, valid, press, release_s});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (press !== (k == 4)) begin
                n_fail++; $display("FAIL reset_restart k=%0d press=%b exp=%b", k, press, (k == 4));
            end
        end
    endtask

    task automatic test_press();
        do_reset();
        button_on = 1'b1; keypad_val = 8'h82;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (press !== (k == 4) || release_s !== 1'b0) begin
                n_fail++; $display("FAIL press_strobe k=%0d press=%b rel=%b exp_press=%b", k, press, release_s, (k == 4));
            end
            n_tests++;
            if (valid !== (k >= 4) || code !== ((k >= 4) ? 8'h82 : 8'h00)) begin
                n_fail++; $display("FAIL press_level k=%0d valid=%b code=%h", k, valid, code);
            end
            n_tests++;
            if (press1 !== (k == 1) || valid1 !== (k >= 1)) begin
                n_fail++; $display("FAIL press_db1 k=%0d press=%b valid=%b exp_press=%b", k, press1, valid1, (k == 1));
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        keypad_val = 8'h82;
        for (int k = 0; k < 12; k++) begin
            button_on = (((k >> 1) & 1) == 0);
            @(negedge clk);
            n_tests++;
            if ({code, valid, press, release_s} !== 11'd0) begin
                n_fail++; $display("FAIL bounce k=%0d got=%h exp=0", k, {code, valid, press, release_s});
            end
        end
    endtask

    task automatic test_release_bounce();
        do_reset();
        button_on = 1'b1; keypad_val = 8'h82;
        repeat (5) @(negedge clk);
        button_on = 1'b0;
        repeat (2) @(negedge clk);
        button_on = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (release_s !== 1'b0 || valid !== 1'b1 || press !== 1'b0) begin
                n_fail++; $display("FAIL rel_bounce k=%0d rel=%b valid=%b press=%b", k, release_s, valid, press);
            end
        end
        button_on = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (release_s !== (k == 4) || valid !== (k < 4) || code !== 8'h82) begin
                n_fail++; $display("FAIL rel_clean k=%0d rel=%b valid=%b code=%h", k, release_s, valid, code);
            end
        end
    endtask

    task automatic test_rollover();
        do_reset();
        button_on = 1'b1; keypad_val = 8'h82;
        repeat (5) @(negedge clk);
        keypad_val = 8'h84;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_tests++;
            if (release_s !== (k == 4) || press !== (k == 9)) begin
                n_fail++; $display("FAIL rollover_strobe k=%0d rel=%b press=%b", k, release_s, press);
            end
            n_tests++;
            if (valid !== (k < 4 || k >= 9) || code !== ((k >= 9) ? 8'h84 : 8'h82)) begin
                n_fail++; $display("FAIL rollover_level k=%0d valid=%b code=%h", k, valid, code);
            end
        end
    endtask

    task automatic test_autorepeat();
        logic exp_p;
        int   n_rel = 0;
        do_reset();
        button_on = 1'b1; keypad_val = 8'h82;
        for (int e = 0; e < 32; e++) begin
            if (e == 23) button_on = 1'b0;
            @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
            exp_p = (e == 4 || e == 12 || e == 15 || e == 18 || e == 21);
`else
            exp_p = (e == 4);
`endif
            if (release_s === 1'b1) n_rel++;
            n_tests++;
            if (press !== exp_p || release_s !== (e == 27)) begin
                n_fail++; $display("FAIL repeat e=%0d press=%b exp=%b rel=%b", e, press, exp_p, release_s);
            end
            n_tests++;
            if (valid !== (e >= 4 && e < 27)) begin
                n_fail++; $display("FAIL repeat_valid e=%0d valid=%b", e, valid);
            end
        end
        n_tests++;
        if (n_rel != 1) begin
            n_fail++; $display("FAIL repeat_release_count got=%0d exp=1", n_rel);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_release_bounce();
        test_rollover();
        test_autorepeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_debounce.md
Name: keypad_debounce

Overview:
- Parametrised keypad debouncer with a press/release event FSM.
- Sits between the keypad scanner (which supplies the raw row/column code and a raw "any key down" flag) and the display/decode logic.
- Publishes a stable key code, a level-valid flag, and single-cycle press/release strobes.

Parameters:
- CODE_W, 8, width of keypad code (row/column one-hot pair).
- DEBOUNCE_CYCLES, 50000, consecutive stable samples required to accept a press or a release; must be >= 1.
- REPEAT_DELAY, 24000000, cycles in HELD before the first auto-repeat strobe (used only with the optional feature).
- REPEAT_PERIOD, 6000000, cycles between later auto-repeat strobes (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- keypad_val  input  CODE_W  raw scanned key code.
- button_on  input  1  raw "a key is down" flag from the scanner.
- no_bounce_keypad  output  CODE_W  debounced key code, registered.
- key_valid  output  1  high while a debounced key is held.
- key_press  output  1  one-cycle strobe on accepted press (and on auto-repeat if enabled).
- key_release  output  1  one-cycle strobe on accepted release.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE and counters are 0.
  - no_bounce_keypad=0, key_valid=0, key_press=0, key_release=0.
  - A reset mid-operation aborts with no strobe emitted.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); saturates, never wraps. All outputs are registered.
- "Stable" means button_on=1 and keypad_val==cand on the current edge (for RELEASE_WAIT it means button_on=0).
- IDLE:
  - On an edge with button_on=1: cand<=keypad_val, cnt<=0, go to PRESS_WAIT.
- PRESS_WAIT:
  - button_on=0: go to IDLE, cnt<=0.
  - button_on=1 and keypad_val!=cand: cand<=keypad_val, cnt<=0, stay in PRESS_WAIT.
  - Otherwise: cnt<=cnt+1.
  - When the incremented cnt equals DEBOUNCE_CYCLES: go to HELD, no_bounce_keypad<=cand, key_valid<=1, key_press<=1 for exactly one cycle.
- Press latency: if button_on is first sampled high at edge 0 and held stable, key_press is high in the cycle after edge DEBOUNCE_CYCLES.
- HELD:
  - button_on=0 or keypad_val!=no_bounce_keypad: go to RELEASE_WAIT, cnt<=0.
  - A different key while held (rollover) is treated as a release; the new key must pass a full press debounce after release completes.
- RELEASE_WAIT:
  - button_on=1 and keypad_val==no_bounce_keypad: return to HELD with no strobe (bounce rejected).
  - Otherwise cnt<=cnt+1.
  - On reaching DEBOUNCE_CYCLES: go to IDLE, key_valid<=0, key_release<=1 for one cycle.
  - no_bounce_keypad retains the last key.
- key_press and key_release are never high in the same cycle. Strobes deassert on the next edge regardless of inputs.
- DEBOUNCE_CYCLES=1: a single stable follow-up sample suffices.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat timer counts from entry to HELD.
  - At REPEAT_DELAY cycles it emits key_press for one cycle, then again every REPEAT_PERIOD cycles while still in HELD.
  - The timer clears on leaving HELD.
  - A RELEASE_WAIT bounce back into HELD restarts the timer at 0.
- Undefined: no repeat timer logic; key_press fires once per accepted press.

Decomposition:
- Package keypad_pkg:
  - enum state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}.
  - Default-parameter localparams.
  - Function cnt_width(n) returning $clog2(n+1).
- Sub-module stable_timer: a parametrised saturating counter with clr/en/done. It is instantiated for debounce, plus a second instance for repeat under the macro.

Test Plan (CODE_W=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
1. Reset low mid-PRESS_WAIT, then high -> all outputs 0, no strobe, FSM restarts from IDLE.
2. button_on=1, keypad_val=8'b1000_0010 held from edge 0 -> key_press high only in the cycle after edge 4; no_bounce_keypad=8'h82; key_valid=1.
3. button_on toggling 1,0,1,0 every 2 cycles -> key_press never asserts; outputs stay 0.
4. Stable press then button_on=0 for 2 cycles, then 1 with the same code -> no key_release, key_valid stays 1.
5. Held 8'h82, switch keypad_val to 8'h84 with button_on=1 -> key_release after 4 edges, then key_press with 8'h84 after a further 4 edges.
6. KEYPAD_AUTOREPEAT_EN, hold 8'h82 for 20 cycles after acceptance -> key_press at HELD+8, +11, +14, +17; released cleanly -> one key_release.
